ula_16bit_seq: RTL and testbench



---
 rtl/ula_16bit_seq.sv | 132 +++++++++++++
 tb/tb_ula_16bit_seq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_16bit_seq.sv
// Sequential W-bit ALU: one 74181-style 4-bit slice reused least-significant
// nibble first, with carry and equality threaded through registers.

module ula_74181 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       c_in,
  output logic [3:0] f,
  output logic       c_out,
  output logic       a_eq_b
);
  logic [3:0] t1, t2;
  logic [4:0] sum;

  // Every 74181 function is t1 plus t2 (arithmetic) or NOT(t1 xor t2) (logic);
  // carries are active-high on both ends.
  assign t1     = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
  assign t2     = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
  assign sum    = {1'b0, t1} + {1'b0, t2} + {4'b0, c_in};
  assign f      = m ? ~(t1 ^ t2) : sum[3:0];
  assign c_out  = sum[4];
  assign a_eq_b = &f;
endmodule

module ula_16bit_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic [3:0]           s,
  input  logic                 m,
  input  logic                 c_in,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] f,
  output logic                 c_out,
  output logic                 a_eq_b
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     a_lat, b_lat;
  logic [3:0]       s_lat;
  logic             m_lat;
  logic             carry;
  logic             eq;

  logic [3:0]       nib_f;
  logic             nib_c_out, nib_eq;

  ula_74181 u_slice (
    .a      (a_lat[4*idx +: 4]),
    .b      (b_lat[4*idx +: 4]),
    .s      (s_lat),
    .m      (m_lat),
    .c_in   (carry),
    .f      (nib_f),
    .c_out  (nib_c_out),
    .a_eq_b (nib_eq)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: next state gets a default before the case so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (idx == LAST_IDX) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      a_lat  <= '0;
      b_lat  <= '0;
      s_lat  <= '0;
      m_lat  <= 1'b0;
      carry  <= 1'b0;
      eq     <= 1'b0;
      f      <= '0;
      c_out  <= 1'b0;
      a_eq_b <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_lat <= a;
          b_lat <= b;
          s_lat <= s;
          m_lat <= m;
          carry <= c_in;
          eq    <= 1'b1;
          idx   <= '0;
        end
        CALC: begin
          f[4*idx +: 4] <= nib_f;
          carry         <= nib_c_out;
          eq            <= eq & nib_eq;
          idx           <= idx + IDX_W'(1);
          // Outputs other than f only change once the last slice resolves.
          if (idx == LAST_IDX) begin
            c_out  <= m_lat ? 1'b0 : nib_c_out;
            a_eq_b <= eq & nib_eq;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ula_16bit_seq.sv
// Scoreboard bench for ula_16bit_seq: directed vectors, start-while-busy,
// mid-operation reset, back-to-back starts and a full function sweep.

module tb_ula_16bit_seq;
  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  typedef struct packed {
    logic [W-1:0] f;
    logic         c;
    logic         eq;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [3:0]   s = '0;
  logic         m = 1'b0, c_in = 1'b0;
  logic         busy, done, c_out, a_eq_b;
  logic [W-1:0] f;

  int   n_vec  = 0;
  int   n_miss = 0;
  exp_t exp_q[$];

  ula_16bit_seq #(.NIBBLES(NIBBLES)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .s      (s),
    .m      (m),
    .c_in   (c_in),
    .busy   (busy),
    .done   (done),
    .f      (f),
    .c_out  (c_out),
    .a_eq_b (a_eq_b)
  );

  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Datasheet function table for one slice; returns {a_eq_b, c_out, f}.
  function automatic logic [5:0] nib181(input logic [3:0] na, nb, ns, input logic nm, nc);
    logic [3:0] x, y, lf;
    logic [4:0] sum;
    case (ns)
      4'h0: begin x = na;        y = 4'h0;      end
      4'h1: begin x = na | nb;   y = 4'h0;      end
      4'h2: begin x = na | ~nb;  y = 4'h0;      end
      4'h3: begin x = 4'hF;      y = 4'h0;      end
      4'h4: begin x = na;        y = na & ~nb;  end
      4'h5: begin x = na | nb;   y = na & ~nb;  end
      4'h6: begin x = na;        y = ~nb;       end
      4'h7: begin x = na & ~nb;  y = 4'hF;      end
      4'h8: begin x = na;        y = na & nb;   end
      4'h9: begin x = na;        y = nb;        end
      4'hA: begin x = na | ~nb;  y = na & nb;   end
      4'hB: begin x = na & nb;   y = 4'hF;      end
      4'hC: begin x = na;        y = na;        end
      4'hD: begin x = na | nb;   y = na;        end
      4'hE: begin x = na | ~nb;  y = na;        end
      default: begin x = na;     y = 4'hF;      end
    endcase
    sum = {1'b0, x} + {1'b0, y} + {4'b0, nc};
    case (ns)
      4'h0: lf = ~na;
      4'h1: lf = ~(na | nb);
      4'h2: lf = ~na & nb;
      4'h3: lf = 4'h0;
      4'h4: lf = ~(na & nb);
      4'h5: lf = ~nb;
      4'h6: lf = na ^ nb;
      4'h7: lf = na & ~nb;
      4'h8: lf = ~na | nb;
      4'h9: lf = ~(na ^ nb);
      4'hA: lf = nb;
      4'hB: lf = na & nb;
      4'hC: lf = 4'hF;
      4'hD: lf = na | ~nb;
      4'hE: lf = na | nb;
      default: lf = na;
    endcase
    if (nm) return {(lf == 4'hF), sum[4], lf};
    return {(sum[3:0] == 4'hF), sum[4], sum[3:0]};
  endfunction

  function automatic exp_t model16(input logic [W-1:0] ma, mb, input logic [3:0] ms,
                                   input logic mm, mc);
    exp_t       r;
    logic       cy;
    logic [5:0] nr;
    cy   = mc;
    r.eq = 1'b1;
    r.f  = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      nr = nib181(ma[4*i +: 4], mb[4*i +: 4], ms, mm, cy);
      r.f[4*i +: 4] = nr[3:0];
      cy   = nr[4];
      r.eq = r.eq & nr[5];
    end
    r.c = mm ? 1'b0 : cy;
    return r;
  endfunction

  // Scoreboard consumer: every done pulse pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("sb_spurious_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("res_f", 32'(f), 32'(e.f));
        check("res_c_out", 32'(c_out), 32'(e.c));
        check("res_a_eq_b", 32'(a_eq_b), 32'(e.eq));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic drive(input logic [W-1:0] ta, tb, input logic [3:0] ts, input logic tm, tc);
    a = ta; b = tb; s = ts; m = tm; c_in = tc;
  endtask

  // One operation: operands scrambled after acceptance; done expected in the
  // NIBBLES+1-th cycle counting the accepting edge.
  task automatic run_op(input logic [W-1:0] ta, tb, input logic [3:0] ts, input logic tm, tc,
                        input exp_t e);
    int cyc = 0;
    wait_idle();
    drive(ta, tb, ts, tm, tc);
    start = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    drive(W'($urandom), W'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 20);
    check("latency", 32'(cyc), 32'(NIBBLES + 1));
  endtask

  initial begin
    exp_t e, e2;
    logic [W-1:0] ra, rb;
    int   seen, d1, d2;

    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_f", 32'(f), 32'd0);
    check("rst_c_out", 32'(c_out), 32'd0);
    check("rst_a_eq_b", 32'(a_eq_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b0, '{f: 16'h0100, c: 1'b0, eq: 1'b0});
    run_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, '{f: 16'h0000, c: 1'b1, eq: 1'b0});
    run_op(16'hA5A5, 16'h0FF0, 4'b0110, 1'b1, 1'b1, '{f: 16'hAA55, c: 1'b0, eq: 1'b0});
    @(negedge clk);
    check("hold_f", 32'(f), 32'hAA55);

    // Reset during the third CALC cycle aborts without a done pulse.
    wait_idle();
    drive(16'h1234, 16'h1111, 4'b1001, 1'b0, 1'b0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_f", 32'(f), 32'd0);
    check("arst_c_out", 32'(c_out), 32'd0);
    check("arst_a_eq_b", 32'(a_eq_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("arst_no_done", 32'(seen), 32'd0);
    run_op(16'h1234, 16'h1111, 4'b1001, 1'b0, 1'b0, '{f: 16'h2345, c: 1'b0, eq: 1'b0});

    // Starts in CALC cycle 2 and in the DONE cycle are ignored.
    wait_idle();
    drive(16'h0F0F, 16'h0101, 4'b1001, 1'b0, 1'b1);
    start = 1'b1;
    exp_q.push_back('{f: 16'h1011, c: 1'b0, eq: 1'b0});
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check("ign_busy", 32'(busy), 32'd1);
      if (c == 5) check("ign_done", 32'(done), 32'd1);
      if (c == 2 || c == 5) begin
        drive(16'hFFFF, 16'hFFFF, 4'b0011, 1'b1, 1'b0);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    start = 1'b0;
    check("ign_idle", 32'(busy), 32'd0);
    check("ign_pulse", 32'(done), 32'd0);

    // Start held high: two operations, one every NIBBLES+2 cycles.
    wait_idle();
    drive(16'h8001, 16'h7FFF, 4'b1001, 1'b0, 1'b0);
    start = 1'b1;
    exp_q.push_back('{f: 16'h0000, c: 1'b1, eq: 1'b0});
    @(posedge clk);
    #1;
    drive(16'h3C3C, 16'h3C3C, 4'b0110, 1'b0, 1'b0);
    exp_q.push_back('{f: 16'hFFFF, c: 1'b0, eq: 1'b1});
    d1 = 0;
    d2 = 0;
    for (int c = 1; c <= 20 && d2 == 0; c++) begin
      @(negedge clk);
      if (done && d1 == 0) d1 = c;
      else if (done) d2 = c;
    end
    start = 1'b0;
    check("b2b_first", 32'(d1), 32'(NIBBLES + 1));
    check("b2b_period", 32'(d2 - d1), 32'(NIBBLES + 2));

    // Full function sweep against the chained-slice model.
    for (int si = 0; si < 16; si++) begin
      for (int mi = 0; mi < 2; mi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          ra = W'($urandom);
          rb = W'($urandom);
          e  = model16(ra, rb, 4'(si), 1'(mi), 1'(ci));
          run_op(ra, rb, 4'(si), 1'(mi), 1'(ci), e);
          e2 = model16(ra, ra, 4'(si), 1'(mi), 1'(ci));
          run_op(ra, ra, 4'(si), 1'(mi), 1'(ci), e2);
        end
      end
    end

    wait_idle();
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
